// File: rtl/jsilicon_pkg.sv
// jsilicon_pkg: shared encodings and defaults for the Jsilicon CPU sequencer.
// The eight main states fit in three bits; ERROR and HOLD need a fourth bit
// and report their low three bits on the debug state bus.
package jsilicon_pkg;

  localparam int unsigned TX_TIMEOUT_DEFAULT = 4096;
  localparam int unsigned CNT_W_DEFAULT      = 16;
  localparam int unsigned STATE_W            = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_WB      = 4'd4,
    ST_REPORT  = 4'd5,
    ST_WAIT_TX = 4'd6,
    ST_NEXT    = 4'd7,
    ST_ERROR   = 4'd8,   // debug code 3'b000, distinguished by fault
    ST_HOLD    = 4'd15   // debug code 3'b111, only reachable with single-step
  } seq_state_t;

  // Counter width able to hold timeout-1; never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  // States in which an instruction is in flight.
  function automatic logic is_active(input seq_state_t s);
    return !((s == ST_IDLE) || (s == ST_ERROR) || (s == ST_HOLD));
  endfunction

endpackage

// File: rtl/cpu_sequencer_tx_watchdog.sv
// tx_watchdog: clearable, enable-gated down-counter bounding the UART wait.
// Loaded with timeout-1 on clear; tc is high once the load has been counted off.
module tx_watchdog
  import jsilicon_pkg::*;
#(
  parameter int unsigned TIMEOUT = TX_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic cnt_en,
  output logic tc
);

  localparam int unsigned CW = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] remaining;

  // Reload on clear, otherwise count down while the sequencer is waiting; ena freezes it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= LOAD;
    end else if (ena) begin
      if (clr) begin
        remaining <= LOAD;
      end else if (cnt_en && (remaining != '0)) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  assign tc = (remaining == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: per-instruction fetch/decode/execute/write-back/report
// controller for the Jsilicon CPU datapath.
// Build option: define SEQ_SINGLE_STEP_EN to add the step input and HOLD state.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | manual mode, waiting for mode=1
//   FETCH    | ir_load pulse
//   DECODE   | decoder outputs settle
//   EXEC     | capture wb_data into uart_data, branch on write_enable
//   WB       | reg_we pulse, watchdog reload
//   REPORT   | wait for UART idle, then uart_start pulse
//   WAIT_TX  | wait for busy to rise, then to fall
//   NEXT     | pc_ena / instruction_finished pulse, retired count
//   HOLD     | single-step only: wait for step
//   ERROR    | UART timeout, sticky until reset
module cpu_sequencer
  import jsilicon_pkg::*;
#(
  parameter int unsigned TX_TIMEOUT = TX_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic             alu_enable,
  input  logic             write_enable,
  input  logic [7:0]       wb_data,
  input  logic             uart_busy,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             ir_load,
  output logic             reg_we,
  output logic             uart_start,
  output logic [7:0]       uart_data,
  output logic             pc_ena,
  output logic             instruction_finished,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       st;
  logic             tx_seen_busy;
  logic [7:0]       uart_data_q;
  logic [CNT_W-1:0] retired_q;
  logic             wd_clr;
  logic             wd_cnt_en;
  logic             wd_tc;
  logic             unused_alu_enable;

  // The ALU/operand mux upstream already folds alu_enable into wb_data.
  assign unused_alu_enable = alu_enable;

  assign wd_clr    = (st == ST_WB);
  assign wd_cnt_en = (st == ST_REPORT) || (st == ST_WAIT_TX);

  tx_watchdog #(
    .TIMEOUT (TX_TIMEOUT)
  ) u_tx_watchdog (
    .clock  (clock),
    .rst_n  (rst_n),
    .ena    (ena),
    .clr    (wd_clr),
    .cnt_en (wd_cnt_en),
    .tc     (wd_tc)
  );

  // Instruction-cycle state machine plus the registers it owns.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ST_IDLE;
      tx_seen_busy <= 1'b0;
      uart_data_q  <= '0;
      retired_q    <= '0;
    end else if (ena) begin
      case (st)
        ST_IDLE: begin
          if (mode) st <= ST_FETCH;
        end
        ST_FETCH: begin
          st <= ST_DECODE;
        end
        ST_DECODE: begin
          st <= ST_EXEC;
        end
        ST_EXEC: begin
          uart_data_q <= wb_data;
          st          <= write_enable ? ST_WB : ST_NEXT;
        end
        ST_WB: begin
          st <= ST_REPORT;
        end
        ST_REPORT: begin
          if (wd_tc) begin
            st <= ST_ERROR;
          end else if (!uart_busy) begin
            tx_seen_busy <= 1'b0;
            st           <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (wd_tc) begin
            st <= ST_ERROR;
          end else if (!tx_seen_busy) begin
            if (uart_busy) tx_seen_busy <= 1'b1;
          end else if (!uart_busy) begin
            st <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
          st <= ST_HOLD;
`else
          st <= mode ? ST_FETCH : ST_IDLE;
`endif
        end
`ifdef SEQ_SINGLE_STEP_EN
        ST_HOLD: begin
          if (step) st <= mode ? ST_FETCH : ST_IDLE;
        end
`endif
        ST_ERROR: begin
          st <= ST_ERROR;
        end
        default: begin
          st <= ST_ERROR;
        end
      endcase
    end
  end

  // Strobes are state decodes gated by ena so a stalled pulse reappears on resume.
  // uart_start also waits for an idle UART and is suppressed once the watchdog expires.
  assign ir_load              = ena && (st == ST_FETCH);
  assign reg_we               = ena && (st == ST_WB);
  assign uart_start           = ena && (st == ST_REPORT) && !uart_busy && !wd_tc;
  assign pc_ena               = ena && (st == ST_NEXT);
  assign instruction_finished = pc_ena;

  assign uart_data = uart_data_q;
  assign busy      = is_active(st);
  assign fault     = (st == ST_ERROR);
  assign state     = st[2:0];
  assign retired   = retired_q;

  // A transmit request must never overlap a busy transmitter.
  a_no_start_when_busy: assert property (
    @(posedge clock) disable iff (!rst_n) !(uart_start && uart_busy)
  );

  // At most one strobe per cycle: each belongs to a different state.
  a_strobes_exclusive: assert property (
    @(posedge clock) disable iff (!rst_n) $onehot0({ir_load, reg_we, uart_start, pc_ena})
  );

endmodule
